char_feeder: RTL and testbench
==============================

# char_feeder

Upstream character-buffering stage for the block checker. Accepts ASCII bytes from a host-side valid/ready write port, folds upper-case letters to lower case, and stores them in a small circular FIFO. Drains one character per clock onto a registered output that drives the checker's 8-bit `in` port. When the FIFO is empty it emits a neutral separator character so the checker always sees a well-formed stream.

## Interface
- `DEPTH`, 8, FIFO entries; must be a power of two, at least 2.
- `IDLE_CHAR`, 8'h20, byte driven on `out_char` when no data is popped (space, a word separator).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; `reset`==0 at a rising edge clears all state.
- `wr_valid`  in  1  host presents a byte on `wr_data`.
- `wr_data`  in  8  ASCII byte from the host.
- `wr_ready`  out  1  FIFO can accept a byte; combinational, equals (`count` < `DEPTH`).
- `hold`  in  1  downstream stall; while 1, no pop and `out_char`/`out_valid` keep their values.
- `out_char`  out  8  registered character to the checker's `in`.
- `out_valid`  out  1  registered; 1 when `out_char` was popped from the FIFO this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, registered.
- `overflow`  out  1  sticky flag; set when a write is attempted while `wr_ready`==0.

## Operation
- Write is accepted at a rising edge when `wr_valid`==1 and `wr_ready`==1. The stored byte is `wr_data`+8'h20 if `wr_data` is in 8'h41..8'h5A. Otherwise it is stored unchanged.
- Pop occurs at a rising edge when `hold`==0 and `count`!=0, evaluated on pre-edge state.
  - On a pop: `out_char` gets the head entry, `out_valid` gets 1, and the read pointer advances.
- When `hold`==0 and `count`==0: `out_char` gets `IDLE_CHAR` and `out_valid` gets 0.
- When `hold`==1: `out_char`, `out_valid` and the read pointer are unchanged. Writes still proceed.
- Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from `DEPTH`-1 to 0.
- `count` is updated as follows:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop.
- Full-FIFO writes are rejected even if a pop happens in the same cycle, because `wr_ready` is computed from pre-edge `count`.
  - The rejected byte is dropped and `overflow` is set.
- `overflow` stays 1 until reset. No other way clears it.
- Data order is strict FIFO. Each accepted byte is emitted exactly once.

## Timing
- Reset values after a rising edge with `reset`==0:
  - `out_char`=`IDLE_CHAR`, `out_valid`=0, `count`=0, `overflow`=0.
  - Both pointers=0.
  - `wr_ready`=1 from the next cycle onward.
- Reset takes priority over every write, pop and hold in the same cycle.
- Reset mid-stream discards all buffered bytes. Memory contents need not be cleared.
- Latency into an empty FIFO with `hold`==0:
  - A byte accepted at edge N appears on `out_char` after edge N+1, with `out_valid`=1.
  - Minimum latency is 2 edges from the `wr_valid` assertion.
- Throughput is one byte per cycle sustained. With continuous writes and no hold, `count` stays at 1.
- `wr_ready` falls in the same cycle that `count` reaches `DEPTH`. It rises in the cycle after the first pop from full.
- `out_char` is never combinationally dependent on any input.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with `wr_valid`=1.
  - Required: `out_char`=8'h20, `out_valid`=0, `count`=0, `overflow`=0, and no byte accepted.
- Case fold and order: write "BeGiN" (8'h42,65,47,69,4E) on consecutive cycles with `hold`=0.
  - Required: `out_char` shows 8'h62,65,67,69,6E on consecutive cycles starting 2 edges after the first write.
  - Required: `count` ≤1 throughout, then 8'h20 with `out_valid`=0.
- Full/overflow: with `hold`=1, write 9 bytes 8'h61..8'h69.
  - Required: `count`=8 and `wr_ready`=0 after the 8th.
  - Required: the 9th is dropped and `overflow`=1.
  - Release `hold`. Required: 8'h61..8'h68 emerge in order, then `IDLE_CHAR`, with `overflow` still 1.
- Simultaneous push/pop and wrap: write 6 bytes with `hold`=1, release, then stream 10 more bytes continuously.
  - Required: `count` stays 6 during the stream.
  - Required: all 16 bytes emerge in order across the pointer wrap.
- Hold mid-stream: while `out_char`=8'h65 with `out_valid`=1, assert `hold` for 3 cycles.
  - Required: `out_char` stays 8'h65 and `out_valid` stays 1 for those 3 cycles.
  - Required: the next byte appears one edge after `hold` drops.
- Reset mid-operation: with `count`=5, pulse `reset`=0 for 1 cycle.
  - Required: `count`=0, `out_char`=8'h20 and `overflow`=0.
  - Required: a subsequent write of 8'h64 appears 2 edges later, and no stale byte is ever emitted.

Source files
------------

// File: rtl/char_feeder.sv
`default_nettype none
// ============================================================================
// Module   : char_feeder
// Purpose  : Case-folding character FIFO feeding the block checker; emits
//            IDLE_CHAR whenever nothing is buffered.
// Revision : 1.0
// ============================================================================
module char_feeder #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] IDLE_CHAR = 8'h20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     hold,
    output logic [7:0]               out_char,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int                  c_AW    = $clog2(DEPTH);
    localparam int                  c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0]     c_FULL  = c_CW'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [7:0]       r_out_char;
    logic             r_out_valid;
    logic             r_overflow;

    logic             w_wr_ready;
    logic             w_wr_en;
    logic             w_pop;
    logic [7:0]       w_fold;

    // Acceptance uses pre-edge occupancy, so a full FIFO rejects even when a
    // pop happens on the same edge.
    assign w_wr_ready = (r_count < c_FULL);
    assign w_wr_en    = wr_valid && w_wr_ready;
    assign w_pop      = !hold && (r_count != '0);
    assign w_fold     = ((wr_data >= 8'h41) && (wr_data <= 8'h5A)) ? (wr_data + 8'h20) : wr_data;

    // Storage carries no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_fold;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_char  <= IDLE_CHAR;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end

            if (w_pop) begin
                r_out_char  <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + c_AW'(1);
            end else if (!hold) begin
                r_out_char  <= IDLE_CHAR;
                r_out_valid <= 1'b0;
            end

            if (wr_valid && !w_wr_ready) begin
                r_overflow <= 1'b1;
            end

            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign wr_ready  = w_wr_ready;
    assign out_char  = r_out_char;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_char_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_feeder
// Purpose  : Scoreboard bench for char_feeder with directed character streams.
// Revision : 1.0
// ============================================================================
module tb_char_feeder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       hold = 1'b0;
    logic [7:0] out_char;
    logic       out_valid;
    logic [3:0] count;
    logic       overflow;

    char_feeder #(.DEPTH(DEPTH), .IDLE_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .hold(hold), .out_char(out_char),
        .out_valid(out_valid), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];

    // Occupancy/flag reference, updated from the bench's own view of the inputs.
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;
    bit   m_ov = 1'b0;
    bit   hold_q = 1'b0;
    bit   reset_q = 1'b0;
    logic [7:0] prev_char = 8'h20;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_cnt <= 0;
            m_ovf <= 1'b0;
            m_ov  <= 1'b0;
        end else begin
            m_cnt <= m_cnt + ((wr_valid && m_cnt < DEPTH) ? 1 : 0) - ((!hold && m_cnt != 0) ? 1 : 0);
            if (wr_valid && m_cnt >= DEPTH) m_ovf <= 1'b1;
            if (!hold) m_ov <= (m_cnt != 0);
        end
        hold_q  <= hold;
        reset_q <= reset;
    end

    // Monitor: checks every cycle on the falling edge, popping on each emission.
    always @(negedge clk) begin
        chk("count", int'(count), m_cnt);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("wr_ready", int'(wr_ready), (m_cnt < DEPTH) ? 1 : 0);
        chk("out_valid", int'(out_valid), int'(m_ov));
        if (!reset_q) begin
            chk("reset_char", int'(out_char), 8'h20);
        end else if (hold_q) begin
            chk("hold_char", int'(out_char), int'(prev_char));
        end else if (m_ov) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h, expected none at %0t", out_char, $time);
            end else begin
                chk("data", int'(out_char), int'(sb.pop_front()));
            end
        end else begin
            chk("idle_char", int'(out_char), 8'h20);
        end
        prev_char = out_char;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            if (sb.size() == 0 && m_cnt == 0) break;
            tick();
        end
        chk({name, "_drain_timeout"}, (k < 40) ? 1 : 0, 1);
        tick();
        chk({name, "_idle_char"}, int'(out_char), 8'h20);
        chk({name, "_idle_valid"}, int'(out_valid), 0);
    endtask

    string s_in;
    string s_exp;

    initial begin
        // Reset with a write pending: nothing may be accepted.
        reset = 1'b0; wr_valid = 1'b1; wr_data = 8'h41;
        tick(); tick();
        chk("rst_count", int'(count), 0);
        chk("rst_char", int'(out_char), 8'h20);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b1; wr_valid = 1'b0;
        tick();

        // Case fold and ordering with a continuous stream.
        s_in = "BeGiN"; s_exp = "begin";
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = s_in[i]; sb.push_back(s_exp[i]);
            tick();
            chk("begin_count_le1", (count <= 4'd1) ? 1 : 0, 1);
        end
        wr_valid = 1'b0;
        drain("begin");

        // Fill to full while held, ninth write must be dropped.
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_data = 8'h61 + 8'(i);
            if (i < 8) sb.push_back(8'h61 + 8'(i));
            tick();
            if (i == 7) begin
                chk("full_count", int'(count), 8);
                chk("full_wr_ready", int'(wr_ready), 0);
                chk("full_ovf_clear", int'(overflow), 0);
            end
        end
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 8);
        wr_valid = 1'b0; hold = 1'b0;
        drain("full");
        chk("ovf_sticky", int'(overflow), 1);

        // Six held, then ten streamed through with simultaneous push/pop.
        s_in = "Feed THE ck@[Z9!"; s_exp = "feed the ck@[z9!";
        for (int i = 0; i < 16; i++) begin
            hold = (i < 6);
            wr_valid = 1'b1; wr_data = s_in[i]; sb.push_back(s_exp[i]);
            tick();
            if (i >= 6) chk("stream_count", int'(count), 6);
        end
        wr_valid = 1'b0; hold = 1'b0;
        drain("wrap");

        // Hold while 'e' is on the output.
        hold = 1'b1;
        s_in = "abcdefg";
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1; wr_data = s_in[i]; sb.push_back(s_in[i]);
            tick();
        end
        wr_valid = 1'b0; hold = 1'b0;
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                tick();
                if (out_char == 8'h65 && out_valid) break;
            end
            chk("hold_reach_e", (k < 20) ? 1 : 0, 1);
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_char_e", int'(out_char), 8'h65);
            chk("hold_valid", int'(out_valid), 1);
        end
        hold = 1'b0;
        tick();
        chk("hold_next_char", int'(out_char), 8'h66);
        chk("hold_next_valid", int'(out_valid), 1);
        drain("hold");

        // Mid-operation reset discards five buffered bytes.
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 8'h70 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("pre_rst_count", int'(count), 5);
        reset = 1'b0; hold = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_char", int'(out_char), 8'h20);
        chk("midrst_ovf", int'(overflow), 0);
        wr_valid = 1'b1; wr_data = 8'h64; sb.push_back(8'h64);
        tick();
        wr_valid = 1'b0;
        tick();
        chk("post_rst_char", int'(out_char), 8'h64);
        chk("post_rst_valid", int'(out_valid), 1);
        drain("post_rst");
        repeat (4) tick();
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
